cpu_controller: RTL and testbench

- Control stage that feeds the register-file/ALU datapath.
- Holds the 16-bit instruction register (IR) and decodes register selects and sign-extended immediates.
- Sequences a Moore FSM that drives every datapath control input (vsel, loada/b/c, loads, asel, bsel, write, readnum, writenum, shift, ALUop).
- Executes one instruction per start pulse and reports idle on w.

---
 rtl/cpu_controller_if.sv | 38 +++
 rtl/cpu_controller.sv | 154 +++++++++++++++
 tb/tb_cpu_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Bus between the instruction source and the controller, and from the controller
// to the register-file/ALU datapath.
//   slave  : controller side (takes in/load/s, drives every control output)
//   master : instruction source / datapath side (drives in/load/s, observes controls)
interface cpu_controller_if;
    logic [15:0] in;        // instruction word to load into IR
    logic        load;      // IR load enable, honoured in WAIT only
    logic        s;         // start pulse, sampled in WAIT
    logic        w;         // high only while idle in WAIT
    logic [2:0]  readnum;   // register-file read select
    logic [2:0]  writenum;  // register-file write select
    logic        write;     // register-file write enable
    logic [3:0]  vsel;      // one-hot writeback select: mdata, sximm8, PC, C
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;      // 1 selects zero for Ain
    logic        bsel;      // 1 selects sximm5 for Bin
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, vsel,
        output loada, loadb, loadc, loads, asel, bsel,
        output shift, ALUop, sximm8, sximm5
    );

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, vsel,
        input  loada, loadb, loadc, loads, asel, bsel,
        input  shift, ALUop, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller.sv
// Control stage for the register-file/ALU datapath. Holds the 16-bit instruction
// register, produces sign-extended immediates and sequences a Moore FSM that
// drives every datapath control input. One instruction executes per start pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces WAIT and clears IR
//   bus   : cpu_controller_if.slave (in/load/s inputs, all control outputs)
module cpu_controller (
    input logic             clk,
    input logic             reset,
    cpu_controller_if.slave bus
);

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // IR fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    logic is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    // IR only loads while idle; if load and s share an edge, DECODE sees the new word.
    always_comb begin
        ir_d = ir_q;
        if (state_q == StWait && bus.load) begin
            ir_d = bus.in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state and Moore outputs; everything defaults to inactive.
    always_comb begin
        state_d      = state_q;
        bus.w        = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.vsel     = 4'b0000;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;

        case (state_q)
            StWait: begin
                bus.w = 1'b1;
                if (bus.s) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWriteImm;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = StGetB;
                end else if (is_alu) begin
                    state_d = StGetA;
                end else begin
                    state_d = StWait;  // unsupported encoding: no side effects
                end
            end
            StWriteImm: begin
                bus.writenum = rn;
                bus.vsel     = 4'b0100;
                bus.write    = 1'b1;
                state_d      = StWait;
            end
            StGetA: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_d     = StGetB;
            end
            StGetB: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_d     = StAlu;
            end
            StAlu: begin
                bus.shift = sh;
                if (is_mov_reg) begin
                    // Ain forced to zero so the ALU passes shifted Rm through
                    bus.asel  = 1'b1;
                    bus.ALUop = 2'b00;
                    bus.loadc = 1'b1;
                end else if (is_mvn) begin
                    bus.asel  = 1'b1;
                    bus.ALUop = 2'b11;
                    bus.loadc = 1'b1;
                end else if (is_cmp) begin
                    bus.ALUop = 2'b01;
                    bus.loads = 1'b1;
                end else begin
                    bus.ALUop = op;
                    bus.loadc = 1'b1;
                end
                state_d = is_cmp ? StWait : StWriteReg;
            end
            StWriteReg: begin
                bus.writenum = rd;
                bus.vsel     = 4'b0001;
                bus.write    = 1'b1;
                state_d      = StWait;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the expected control vector of every
// cycle is queued when an instruction is launched and compared on each negedge.
module tb_cpu_controller;

    logic clk;
    logic reset;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic [3:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } ctrl_t;

    localparam int SWait     = 0;
    localparam int SDecode   = 1;
    localparam int SWriteImm = 2;
    localparam int SGetA     = 3;
    localparam int SGetB     = 4;
    localparam int SAlu      = 5;
    localparam int SWriteReg = 6;

    ctrl_t exp_q[$];
    int    vectors;
    int    miscompares;

    function automatic ctrl_t observe();
        ctrl_t o;
        o.w        = bus.w;
        o.readnum  = bus.readnum;
        o.writenum = bus.writenum;
        o.write    = bus.write;
        o.vsel     = bus.vsel;
        o.loada    = bus.loada;
        o.loadb    = bus.loadb;
        o.loadc    = bus.loadc;
        o.loads    = bus.loads;
        o.asel     = bus.asel;
        o.bsel     = bus.bsel;
        o.shift    = bus.shift;
        o.aluop    = bus.ALUop;
        o.sximm8   = bus.sximm8;
        o.sximm5   = bus.sximm5;
        return o;
    endfunction

    // Expected outputs of one state for a given IR, straight from the state table.
    function automatic ctrl_t vec(input int st, input logic [15:0] ir);
        ctrl_t v;
        v        = '0;
        v.sximm8 = {{8{ir[7]}}, ir[7:0]};
        v.sximm5 = {{11{ir[4]}}, ir[4:0]};
        case (st)
            SWait:     v.w = 1'b1;
            SWriteImm: begin v.writenum = ir[10:8]; v.vsel = 4'b0100; v.write = 1'b1; end
            SGetA:     begin v.readnum = ir[10:8]; v.loada = 1'b1; end
            SGetB:     begin v.readnum = ir[2:0]; v.loadb = 1'b1; end
            SAlu: begin
                v.shift = ir[4:3];
                if (ir[15:11] == 5'b11000) begin
                    v.asel = 1'b1; v.aluop = 2'b00; v.loadc = 1'b1;
                end else if (ir[15:11] == 5'b10111) begin
                    v.asel = 1'b1; v.aluop = 2'b11; v.loadc = 1'b1;
                end else if (ir[15:11] == 5'b10101) begin
                    v.aluop = 2'b01; v.loads = 1'b1;
                end else begin
                    v.aluop = ir[12:11]; v.loadc = 1'b1;
                end
            end
            SWriteReg: begin v.writenum = ir[7:5]; v.vsel = 4'b0001; v.write = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    // Queue the per-cycle outputs from DECODE through the return to WAIT.
    task automatic push_seq(input logic [15:0] ir);
        logic [4:0] key;
        key = ir[15:11];
        exp_q.push_back(vec(SDecode, ir));
        if (key == 5'b11010) begin
            exp_q.push_back(vec(SWriteImm, ir));
        end else if (key == 5'b11000 || key == 5'b10111) begin
            exp_q.push_back(vec(SGetB, ir));
            exp_q.push_back(vec(SAlu, ir));
            exp_q.push_back(vec(SWriteReg, ir));
        end else if (key == 5'b10100 || key == 5'b10101 || key == 5'b10110) begin
            exp_q.push_back(vec(SGetA, ir));
            exp_q.push_back(vec(SGetB, ir));
            exp_q.push_back(vec(SAlu, ir));
            if (key != 5'b10101) exp_q.push_back(vec(SWriteReg, ir));
        end
        exp_q.push_back(vec(SWait, ir));
    endtask

    // Launch ir (load and s together), optionally keep s/load held for repeats,
    // optionally assert load with a different word mid-instruction.
    task automatic run_instr(input logic [15:0] ir, input int reps, input bit hold,
                             input bit mid_load, input string name);
        ctrl_t exp_v;
        ctrl_t obs;
        int    step;
        @(negedge clk);
        bus.in   = ir;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        for (int r = 0; r < reps; r++) push_seq(ir);
        if (!hold) begin
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            bus.s    = 1'b0;
        end
        step = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs   = observe();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s step %0d: got %h required %h", name, step, obs, exp_v);
            end
            if (mid_load && step == 0) begin
                bus.in   = 16'h5A5A;
                bus.load = 1'b1;
            end
            step++;
        end
        bus.load = 1'b0;
        bus.s    = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_t obs;
        reset    = 1'b1;
        bus.in   = 16'h0000;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = observe();
        vectors++;
        if (obs !== vec(SWait, 16'h0000)) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", obs, vec(SWait, 16'h0000));
        end
        reset = 1'b0;
        // load without start just updates IR and stays idle
        bus.in   = 16'hD1F6;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        obs = observe();
        vectors++;
        if (obs !== vec(SWait, 16'hD1F6)) begin
            miscompares++;
            $display("FAIL load_in_wait: got %h required %h", obs, vec(SWait, 16'hD1F6));
        end
    endtask

    task automatic test_mov_imm();
        run_instr(16'hD007, 1, 1'b0, 1'b0, "mov_imm_r0_7");
        run_instr(16'hD1F6, 1, 1'b0, 1'b0, "mov_imm_r1_neg10");
    endtask

    task automatic test_alu_ops();
        run_instr(16'hA049, 1, 1'b0, 1'b0, "add_r2_r0_r1_lsl1");
        run_instr(16'hB049, 1, 1'b0, 1'b0, "and_r2_r0_r1_lsl1");
        run_instr(16'hA801, 1, 1'b0, 1'b0, "cmp_r0_r1");
        run_instr(16'hB861, 1, 1'b0, 1'b0, "mvn_r3_r1");
        run_instr(16'hC061, 1, 1'b0, 1'b0, "mov_reg_r3_r1");
    endtask

    task automatic test_illegal();
        run_instr(16'hE000, 1, 1'b0, 1'b0, "illegal_e000");
        run_instr(16'hD800, 1, 1'b0, 1'b0, "illegal_mov_op11");
    endtask

    task automatic test_back_to_back();
        run_instr(16'hD20F, 2, 1'b1, 1'b0, "back_to_back_s_held");
    endtask

    task automatic test_mid_load();
        run_instr(16'hA049, 1, 1'b0, 1'b1, "load_ignored_mid_instr");
    endtask

    task automatic test_reset_mid();
        ctrl_t exp_v;
        ctrl_t obs;
        @(negedge clk);
        bus.in   = 16'hA049;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        exp_q.push_back(vec(SDecode, 16'hA049));
        exp_q.push_back(vec(SGetA, 16'hA049));
        exp_q.push_back(vec(SGetB, 16'hA049));
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs   = observe();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid_pre step %0d: got %h required %h", i, obs, exp_v);
            end
        end
        // now in GET_B: reset must take effect without waiting for a clock edge
        reset = 1'b1;
        #1;
        obs = observe();
        vectors++;
        if (obs !== vec(SWait, 16'h0000)) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h required %h", obs, vec(SWait, 16'h0000));
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = observe();
            vectors++;
            if (obs !== vec(SWait, 16'h0000)) begin
                miscompares++;
                $display("FAIL reset_mid_after %0d: got %h required %h", i, obs,
                         vec(SWait, 16'h0000));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_mov_imm();
        test_alu_ops();
        test_illegal();
        test_back_to_back();
        test_mid_load();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
